sa_act_feeder: RTL
==================

// Module: sa_act_feeder
// PURPOSE
//  Upstream controller/feeder for the ROWSxCOLS weight-stationary systolic array.
//  Runs one tile per job: clears the PE weights, streams ROWS weight rows down the
//  columns, then feeds activation vectors into the rows with the diagonal skew
//  (row i delayed i cycles) and drives per-row MAC enables. Sits between the
//  activation/weight buffers (valid/ready) and the array's row/column inputs.
// PARAMETERS
//  ROWS     4    array rows = activation lanes = weight rows per tile
//  COLS     4    array columns = weight lanes per row
//  BW_ACT   8    activation width
//  BW_WET   8    weight width
//  BW_ACCU  32   column input width to the top PE row
//  LEN_W    8    width of cfg_len (vectors per job)
// PORTS
//  clk             in   1             clock
//  reset           in   1             synchronous, active-high reset
//  cfg_start       in   1             job start pulse, sampled in IDLE only
//  cfg_len         in   LEN_W         activation vectors in job, sampled with cfg_start
//  cfg_busy        out  1             high in every state except IDLE
//  cfg_done        out  1             1-cycle pulse when the last skewed vector has left
//  wt_valid/ready  in/out 1           weight-row handshake
//  wt_data         in   COLS*BW_WET   one weight row, lane c -> column c
//  act_valid/ready in/out 1           activation-vector handshake
//  act_data        in   ROWS*BW_ACT   one vector, lane i -> row i
//  arr_clear_wt    out  1             to PE clear-weight input, all PEs
//  arr_wsel        out  1             to PE weight/partial select (1 = weight load)
//  arr_wdata       out  COLS*BW_ACCU  to top-row column inputs
//  arr_act         out  ROWS*BW_ACT   to row activation inputs, skewed
//  arr_mac_en      out  ROWS          per-row MAC enable, skewed with arr_act
// BEHAVIOUR
//  - Reset: FSM=IDLE; every output and every skew/pipeline register 0; wt_ready=act_ready=0.
//  - FSM: IDLE -start-> CLEAR(1 cyc, arr_clear_wt=1) -> WLOAD -> WSETTLE(1 cyc) -> STREAM
//    -> DRAIN -> DONE(1 cyc, cfg_done=1) -> IDLE. cfg_start outside IDLE is ignored.
//  - WLOAD: wt_ready=1; each accepted beat (valid&ready) asserts arr_wsel for that cycle;
//    exactly ROWS beats, first beat destined for the bottom row; leave after the ROWSth.
//  - arr_wdata lags arr_wsel by one cycle (matches the PE's registered select); each lane
//    sign-extended BW_WET->BW_ACCU; arr_wdata=0 when no beat is pending.
//  - STREAM: act_ready=1 until cfg_len beats accepted; wt_ready=0. No beat in a cycle
//    -> bubble: that slot carries mac_en=0, act=0 down every row.
//  - Skew: beat accepted in cycle t appears on row i at cycle t+1+i (arr_act lane i,
//    arr_mac_en[i]=1); rows never see a stale value, act lane forced 0 when mac_en=0.
//  - DRAIN: lasts ROWS cycles, until row ROWS-1 has presented the last beat; DONE follows.
//  - cfg_len=0: STREAM exits immediately, DRAIN still runs ROWS cycles (all bubbles).
//  - Counters: beat counter LEN_W bits, saturating at cfg_len; weight counter clog2(ROWS)+1.
//  - Reset mid-job: immediate return to IDLE, skew lines flushed, no cfg_done.
//  - wt_valid during STREAM and act_valid during WLOAD are held off (ready=0), not dropped.
// CONFIGURATION
//  SA_FEEDER_WT_REUSE_EN defined: adds input cfg_reuse_wt (1 bit, sampled with
//    cfg_start); when 1, IDLE goes straight to STREAM, skipping CLEAR/WLOAD/WSETTLE, and
//    arr_clear_wt/arr_wsel stay 0 for the job.
//  Undefined: no port; every job performs CLEAR and WLOAD.
// STRUCTURE
//  - Package sa_pkg: state enum (IDLE,CLEAR,WLOAD,WSETTLE,STREAM,DRAIN,DONE), width
//    localparams (CNT_W=$clog2(ROWS)+1), shared with the array and drain-side blocks.
//  - Sub-module sa_skew_line #(DEPTH,W): {valid,data} shift register, synchronous reset,
//    instantiated per row with DEPTH=i (DEPTH=0 = wire after the common output register).
// TESTING
//  1 reset mid-STREAM (after 3 of 8 beats) -> next cycle all outputs 0, cfg_busy=0, no done.
//  2 ROWS=4, wt rows 1..4 back-to-back -> arr_wsel high 4 cycles, arr_wdata lane0 = 1,2,3,4
//    one cycle later; wt_data lane = 8'hFF -> arr_wdata lane = 32'hFFFFFFFF.
//  3 cfg_len=3, act_data {4,3,2,1} accepted at t -> row0=1 at t+1, row3=4 at t+4, mac_en
//    one-hot diagonal; cfg_done exactly ROWS+1 cycles after the last accept.
//  4 act_valid low for 2 cycles mid-stream -> 2 bubble slots (mac_en=0, act=0) per row,
//    total accepted beats still cfg_len.
//  5 cfg_len=0 -> CLEAR, WLOAD, then cfg_done after ROWS drain cycles, arr_mac_en never 1.
//  6 SA_FEEDER_WT_REUSE_EN, cfg_reuse_wt=1 -> no arr_clear_wt/arr_wsel, first act accept
//    one cycle after cfg_start; cfg_start while busy -> ignored.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared definitions for the weight-stationary systolic array slice: the feeder
// FSM state encoding and the counter-width helper used by the feeder, array and
// drain-side blocks.
package sa_pkg;

    // Feeder job phases, in the order a normal job walks through them.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        WLOAD   = 3'd2,
        WSETTLE = 3'd3,
        STREAM  = 3'd4,
        DRAIN   = 3'd5,
        DONE    = 3'd6
    } sa_state_e;

    // Default array geometry shared across the slice.
    localparam int SA_ROWS = 4;
    localparam int SA_COLS = 4;

    // Weight/drain counters must be able to hold the value ROWS itself.
    localparam int CNT_W = $clog2(SA_ROWS) + 1;

    // Same rule as CNT_W, for blocks instantiated with a non-default row count.
    function automatic int cnt_width(input int rows);
        return $clog2(rows) + 1;
    endfunction

endpackage

// File: rtl/sa_skew_line.sv
// Per-row skew delay for the activation stream: a {valid,data} shift register of
// DEPTH stages. DEPTH=0 is a plain wire, because the feeder already registers the
// accepted vector once before fanning it out to the rows. Data is zeroed whenever
// valid is low, so a bubble never carries a stale activation down the line.
module sa_skew_line #(
    parameter int DEPTH = 1,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    if (DEPTH == 0) begin : g_wire
        // Row 0 has no skew; the clock and reset are simply not needed here.
        logic unused_clk_rst;
        assign unused_clk_rst = clk | reset;
        assign out_valid      = in_valid;
        assign out_data       = in_valid ? in_data : '0;
    end else begin : g_pipe
        logic [DEPTH-1:0] v_pipe;
        logic [W-1:0]     d_pipe [DEPTH];

        // Shift {valid,data} one stage per cycle; reset flushes every stage.
        always_ff @(posedge clk) begin
            if (reset) begin
                v_pipe <= '0;
                for (int k = 0; k < DEPTH; k++) begin
                    d_pipe[k] <= '0;
                end
            end else begin
                v_pipe[0] <= in_valid;
                d_pipe[0] <= in_valid ? in_data : '0;
                for (int k = 1; k < DEPTH; k++) begin
                    v_pipe[k] <= v_pipe[k-1];
                    d_pipe[k] <= d_pipe[k-1];
                end
            end
        end

        assign out_valid = v_pipe[DEPTH-1];
        assign out_data  = d_pipe[DEPTH-1];
    end

endmodule

// File: rtl/sa_act_feeder.sv
// Upstream feeder for the ROWSxCOLS weight-stationary systolic array. One job:
// clear PE weights, load ROWS weight rows down the columns, then stream cfg_len
// activation vectors into the rows with a diagonal skew (row i delayed i cycles)
// and matching per-row MAC enables.
//
// Handshakes: a beat transfers on a rising clk edge where valid && ready are both
// high. ready is registered and never depends on valid; the source must hold
// valid and data stable until the transfer. A low ready holds the source off, it
// never drops a beat.
//
// Optional build macro SA_FEEDER_WT_REUSE_EN adds cfg_reuse_wt: when set at
// cfg_start the job skips CLEAR/WLOAD/WSETTLE and reuses the resident weights.
module sa_act_feeder
    import sa_pkg::*;
#(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int BW_ACT  = 8,
    parameter int BW_WET  = 8,
    parameter int BW_ACCU = 32,
    parameter int LEN_W   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cfg_start,
    input  logic [LEN_W-1:0]        cfg_len,
`ifdef SA_FEEDER_WT_REUSE_EN
    input  logic                    cfg_reuse_wt,
`endif
    output logic                    cfg_busy,
    output logic                    cfg_done,
    input  logic                    wt_valid,
    output logic                    wt_ready,
    input  logic [COLS*BW_WET-1:0]  wt_data,
    input  logic                    act_valid,
    output logic                    act_ready,
    input  logic [ROWS*BW_ACT-1:0]  act_data,
    output logic                    arr_clear_wt,
    output logic                    arr_wsel,
    output logic [COLS*BW_ACCU-1:0] arr_wdata,
    output logic [ROWS*BW_ACT-1:0]  arr_act,
    output logic [ROWS-1:0]         arr_mac_en,
    output sa_state_e               dbg_state
);

    localparam int            CW       = cnt_width(ROWS);
    localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);

    sa_state_e          state;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   beat_cnt;
    logic [CW-1:0]      wt_cnt;
    logic [CW-1:0]      drain_cnt;
    logic               wt_fire;
    logic               act_fire;
    logic               reuse_req;

    logic [COLS*BW_ACCU-1:0] wdata_ext;
    logic [COLS*BW_ACCU-1:0] wdata_q;
    logic                    slot_v;
    logic [ROWS*BW_ACT-1:0]  slot_d;
    logic [ROWS-1:0]         row_v;
    logic [ROWS*BW_ACT-1:0]  row_d;

`ifdef SA_FEEDER_WT_REUSE_EN
    assign reuse_req = cfg_reuse_wt;
`else
    assign reuse_req = 1'b0;
`endif

    assign wt_fire  = wt_valid & wt_ready;
    assign act_fire = act_valid & act_ready;

    // Job sequencer: phase transitions plus the registered ready/clear/done strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            len_q        <= '0;
            beat_cnt     <= '0;
            wt_cnt       <= '0;
            drain_cnt    <= '0;
            wt_ready     <= 1'b0;
            act_ready    <= 1'b0;
            arr_clear_wt <= 1'b0;
            cfg_done     <= 1'b0;
        end else begin
            arr_clear_wt <= 1'b0;
            cfg_done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        len_q     <= cfg_len;
                        beat_cnt  <= '0;
                        wt_cnt    <= '0;
                        drain_cnt <= '0;
                        if (reuse_req) begin
                            // Resident weights are kept: go straight to streaming.
                            state     <= STREAM;
                            act_ready <= (cfg_len != '0);
                        end else begin
                            state        <= CLEAR;
                            arr_clear_wt <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    state    <= WLOAD;
                    wt_ready <= 1'b1;
                end
                WLOAD: begin
                    if (wt_fire) begin
                        wt_cnt <= wt_cnt + CW'(1);
                        if (wt_cnt == LAST_ROW) begin
                            wt_ready <= 1'b0;
                            state    <= WSETTLE;
                        end
                    end
                end
                WSETTLE: begin
                    // One idle cycle lets the last weight settle in the PEs.
                    state     <= STREAM;
                    act_ready <= (len_q != '0);
                end
                STREAM: begin
                    if (len_q == '0) begin
                        state <= DRAIN;
                    end else if (act_fire && beat_cnt != len_q) begin
                        beat_cnt <= beat_cnt + LEN_W'(1);
                        if (beat_cnt + LEN_W'(1) == len_q) begin
                            act_ready <= 1'b0;
                            state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Wait until the bottom row has presented the last beat.
                    if (drain_cnt == LAST_ROW) begin
                        state    <= DONE;
                        cfg_done <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign cfg_busy  = (state != IDLE);
    assign dbg_state = state;

    // Sign-extend each weight lane to the column accumulator width.
    for (genvar c = 0; c < COLS; c++) begin : g_wext
        assign wdata_ext[c*BW_ACCU +: BW_ACCU] =
            {{(BW_ACCU-BW_WET){wt_data[c*BW_WET + BW_WET - 1]}}, wt_data[c*BW_WET +: BW_WET]};
    end

    // Datapath registers: weight lags its select by one cycle, activations get a
    // common output register ahead of the per-row skew lines.
    always_ff @(posedge clk) begin
        if (reset) begin
            wdata_q <= '0;
            slot_v  <= 1'b0;
            slot_d  <= '0;
        end else begin
            wdata_q <= wt_fire ? wdata_ext : '0;
            slot_v  <= act_fire;
            slot_d  <= act_fire ? act_data : '0;
        end
    end

    assign arr_wsel  = wt_fire;
    assign arr_wdata = wdata_q;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        sa_skew_line #(
            .DEPTH (r),
            .W     (BW_ACT)
        ) u_skew (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (slot_v),
            .in_data   (slot_d[r*BW_ACT +: BW_ACT]),
            .out_valid (row_v[r]),
            .out_data  (row_d[r*BW_ACT +: BW_ACT])
        );

        assign arr_mac_en[r]                = row_v[r];
        assign arr_act[r*BW_ACT +: BW_ACT]  = row_v[r] ? row_d[r*BW_ACT +: BW_ACT] : '0;
    end

endmodule
